// File: rtl/led_line_if.sv
// led_line_if: line-shift handshake and frame-RAM read port between the row/PWM controller and led_line_shifter.
// LINE_TEST_PATTERN_EN adds the test_pattern request bit.
interface led_line_if #(
    parameter int ROW_BITS = 5,
    parameter int COL_BITS = 6,
    parameter int DATA_W   = 24
);
    logic                         next_line_begin;
    logic [ROW_BITS-1:0]          next_line_addr;
    logic [3:0]                   next_line_pwm;
    logic                         base_addr;
    logic                         ram_en;
    logic                         next_line_done;
    logic                         ram_re;
    logic [ROW_BITS+COL_BITS:0]   ram_addr;
    logic [DATA_W-1:0]            ram_rdata;
`ifdef LINE_TEST_PATTERN_EN
    logic                         test_pattern;
    modport master (
        output next_line_begin, next_line_addr, next_line_pwm, base_addr, ram_en, ram_rdata, test_pattern,
        input  next_line_done, ram_re, ram_addr
    );
    modport slave (
        input  next_line_begin, next_line_addr, next_line_pwm, base_addr, ram_en, ram_rdata, test_pattern,
        output next_line_done, ram_re, ram_addr
    );
`else
    modport master (
        output next_line_begin, next_line_addr, next_line_pwm, base_addr, ram_en, ram_rdata,
        input  next_line_done, ram_re, ram_addr
    );
    modport slave (
        input  next_line_begin, next_line_addr, next_line_pwm, base_addr, ram_en, ram_rdata,
        output next_line_done, ram_re, ram_addr
    );
`endif
endinterface

// File: rtl/led_line_shifter.sv
// led_line_shifter: reads one row of pixel pairs from frame RAM, selects a PWM bit-plane and shifts it to HUB75 pins.
// LINE_TEST_PATTERN_EN replaces RAM data with a column/row test pattern when requested at line start.
module led_line_shifter #(
    parameter int COLS     = 64,
    parameter int COL_BITS = 6,
    parameter int ROW_BITS = 5,
    parameter int PWM_BITS = 4,
    parameter int DATA_W   = 24
) (
    input  logic      clk_25MHz,
    input  logic      rst_n,
    led_line_if.slave bus,
    output logic      sclk,
    output logic      r0,
    output logic      g0,
    output logic      b0,
    output logic      r1,
    output logic      g1,
    output logic      b1
);
    typedef enum logic [2:0] {IDLE, READ, CAPTURE, CLKHI, DONE} state_t;

    localparam logic [COL_BITS-1:0] LAST = COL_BITS'(COLS - 1);

    state_t                     state;
    logic [COL_BITS-1:0]        col;
    logic [ROW_BITS-1:0]        row;
    logic                       bank;
    logic [3:0]                 pwm;
    logic                       tp;
    logic                       tp_in;
    logic                       done;
    logic [ROW_BITS+COL_BITS:0] addr_q;
    logic [5:0]                 rgb_q;
    logic [5:0]                 raw;
    logic [5:0]                 sel;
    logic [DATA_W-1:0]          word;
    logic                       pwm_ok;

`ifdef LINE_TEST_PATTERN_EN
    assign tp_in = bus.test_pattern;
`else
    assign tp_in = 1'b0;
`endif

    // Shifting by pwm lines the selected plane up with each field's MSB position.
    always_comb begin
        word = bus.ram_rdata << pwm;
        raw = '0;
        for (int f = 0; f < 6; f++) raw[5-f] = word[DATA_W-1-f*PWM_BITS];
        pwm_ok = {1'b0, pwm} < 5'(PWM_BITS);
        sel = !pwm_ok ? 6'b0 : tp ? {col[0], col[1], row[0], ~col[0], ~col[1], ~row[0]} : raw;
    end

    // Pins follow the fresh read data during CAPTURE, so they settle a full cycle before sclk rises.
    assign {r0, g0, b0, r1, g1, b1} = (state == CAPTURE) ? sel : rgb_q;
    assign bus.ram_re         = (state == READ) && bus.ram_en && !tp;
    assign bus.ram_addr       = addr_q;
    assign bus.next_line_done = done;

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            col    <= '0;
            row    <= '0;
            bank   <= 1'b0;
            pwm    <= '0;
            tp     <= 1'b0;
            addr_q <= '0;
            rgb_q  <= '0;
            sclk   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.next_line_begin) begin
                    row    <= bus.next_line_addr;
                    bank   <= bus.base_addr;
                    pwm    <= bus.next_line_pwm;
                    tp     <= tp_in;
                    col    <= '0;
                    addr_q <= {bus.base_addr, bus.next_line_addr, {COL_BITS{1'b0}}};
                    state  <= READ;
                end
                READ: if (bus.ram_en || tp) state <= CAPTURE;
                CAPTURE: begin
                    rgb_q <= sel;
                    sclk  <= 1'b1;
                    state <= CLKHI;
                end
                CLKHI: begin
                    sclk <= 1'b0;
                    if (col == LAST) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        col    <= col + 1'b1;
                        addr_q <= {bank, row, col + 1'b1};
                        state  <= READ;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    col   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_led_line_shifter.sv
// tb_led_line_shifter: scoreboard bench for led_line_shifter; expected addresses and pixels are queued per line.
module tb_led_line_shifter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sclk, r0, g0, b0, r1, g1, b1;
    logic [5:0] rgb;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rises = 0;
    int begin_cyc = 0;
    logic [11:0] addr_q[$];
    logic [5:0]  rgb_exp_q[$];
    logic [23:0] ram_word = 24'h0;
    logic        addr_mix = 1'b0;

    led_line_if #(.ROW_BITS(5), .COL_BITS(6), .DATA_W(24)) bus ();

    led_line_shifter #(.COLS(64), .COL_BITS(6), .ROW_BITS(5), .PWM_BITS(4), .DATA_W(24)) dut (
        .clk_25MHz(clk), .rst_n(rst_n), .bus(bus),
        .sclk(sclk), .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1)
    );

    assign rgb = {r0, g0, b0, r1, g1, b1};

    always #20 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [23:0] word_of(input logic [11:0] a);
        return addr_mix ? (ram_word ^ {a, a}) : ram_word;
    endfunction

    function automatic logic [5:0] exp_rgb(input logic [23:0] w, input logic [3:0] p);
        logic [5:0] r;
        logic [3:0] fld;
        r = '0;
        if (p < 4)
            for (int f = 0; f < 6; f++) begin
                fld = w[23-4*f -: 4];
                r[5-f] = fld[3-p];
            end
        return r;
    endfunction

    // Synchronous frame RAM: data appears the cycle after the read strobe, garbage otherwise.
    always @(posedge clk) bus.ram_rdata <= bus.ram_re ? word_of(bus.ram_addr) : 24'($urandom);

    initial begin
        logic sclk_d;
        logic [5:0] rgb_d;
        logic [11:0] ea;
        logic [5:0] er;
        sclk_d = 1'b0;
        rgb_d = '0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.ram_re === 1'b1) begin
                total++;
                if (addr_q.size() == 0) begin
                    bad++;
                    $display("FAIL ram_re_unexpected: got ram_re=1 at addr %h, want no read", bus.ram_addr);
                end else begin
                    ea = addr_q.pop_front();
                    if (bus.ram_addr !== ea) begin
                        bad++;
                        $display("FAIL ram_addr: got %h want %h", bus.ram_addr, ea);
                    end
                end
            end
            if (rst_n && sclk === 1'b1 && sclk_d !== 1'b1) begin
                rises++;
                total++;
                if (rgb_exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sclk_unexpected: got sclk rise, want none");
                end else begin
                    er = rgb_exp_q.pop_front();
                    if (rgb !== er || rgb_d !== er) begin
                        bad++;
                        $display("FAIL rgb_at_sclk: got %b (cycle before %b) want %b", rgb, rgb_d, er);
                    end
                end
            end
            sclk_d = sclk;
            rgb_d = rgb;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start_line(input logic [4:0] a, input logic [3:0] p, input logic b);
        for (int c = 0; c < 64; c++) begin
            addr_q.push_back({b, a, 6'(c)});
            rgb_exp_q.push_back(exp_rgb(word_of({b, a, 6'(c)}), p));
        end
        bus.next_line_addr = a;
        bus.next_line_pwm = p;
        bus.base_addr = b;
        bus.next_line_begin = 1'b1;
        begin_cyc = cyc;
        tick();
        bus.next_line_begin = 1'b0;
        bus.next_line_addr = 5'($urandom);
        bus.next_line_pwm = 4'($urandom);
        bus.base_addr = 1'($urandom);
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 0; i < 600 && lat < 0; i++) begin
            tick();
            if (bus.next_line_done === 1'b1) lat = cyc - begin_cyc;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        total++;
        if ({rgb, sclk, bus.ram_re, bus.next_line_done} !== 9'b0) begin
            bad++;
            $display("FAIL reset_outputs: got rgb=%b sclk=%b re=%b done=%b want all 0", rgb, sclk, bus.ram_re, bus.next_line_done);
        end
        total++;
        if (bus.ram_addr !== 12'h0) begin
            bad++;
            $display("FAIL reset_addr: got %h want 000", bus.ram_addr);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int lat;
        ram_word = 24'hF00F00;
        addr_mix = 1'b0;
        rises = 0;
        start_line(5'd5, 4'd0, 1'b1);
        wait_done(lat);
        total++;
        if (lat !== 193) begin bad++; $display("FAIL basic_latency: got %0d want 193", lat); end
        total++;
        if (rises !== 64) begin bad++; $display("FAIL basic_sclk_rises: got %0d want 64", rises); end
        total++;
        if (addr_q.size() + rgb_exp_q.size() !== 0) begin
            bad++;
            $display("FAIL basic_leftover: got %0d pending want 0", addr_q.size() + rgb_exp_q.size());
        end
        tick();
        total++;
        if (bus.next_line_done !== 1'b0) begin bad++; $display("FAIL basic_done_width: got %b want 0", bus.next_line_done); end
        total++;
        if (rgb !== 6'b100100) begin bad++; $display("FAIL basic_rgb_hold: got %b want 100100", rgb); end
    endtask

    task automatic test_plane();
        int lat;
        ram_word = 24'h812341;
        addr_mix = 1'b0;
        rises = 0;
        start_line(5'd9, 4'd3, 1'b0);
        wait_done(lat);
        total++;
        if (lat !== 193 || rises !== 64) begin bad++; $display("FAIL plane3_timing: got lat=%0d rises=%0d want 193/64", lat, rises); end
        total++;
        if (rgb !== 6'b010101) begin bad++; $display("FAIL plane3_rgb: got %b want 010101", rgb); end
        tick();
        rises = 0;
        start_line(5'd9, 4'd4, 1'b0);
        wait_done(lat);
        total++;
        if (lat !== 193 || rises !== 64) begin bad++; $display("FAIL plane4_timing: got lat=%0d rises=%0d want 193/64", lat, rises); end
        total++;
        if (rgb !== 6'b0) begin bad++; $display("FAIL plane4_rgb: got %b want 000000", rgb); end
        total++;
        if (addr_q.size() + rgb_exp_q.size() !== 0) begin
            bad++;
            $display("FAIL plane_leftover: got %0d pending want 0", addr_q.size() + rgb_exp_q.size());
        end
        tick();
    endtask

    task automatic test_stall();
        int lat;
        int stall_bad;
        ram_word = 24'h5A5A5A;
        addr_mix = 1'b1;
        rises = 0;
        stall_bad = 0;
        start_line(5'd20, 4'd1, 1'b0);
        for (int i = 0; i < 100 && rises < 10; i++) tick();
        bus.ram_en = 1'b0;
        repeat (7) begin
            tick();
            if (bus.ram_re !== 1'b0 || sclk !== 1'b0) stall_bad++;
        end
        @(posedge clk);
        #1;
        bus.ram_en = 1'b1;
        total++;
        if (stall_bad !== 0) begin bad++; $display("FAIL stall_activity: got %0d active cycles want 0", stall_bad); end
        wait_done(lat);
        total++;
        if (lat !== 200) begin bad++; $display("FAIL stall_latency: got %0d want 200", lat); end
        total++;
        if (rises !== 64) begin bad++; $display("FAIL stall_sclk_rises: got %0d want 64", rises); end
        total++;
        if (addr_q.size() + rgb_exp_q.size() !== 0) begin
            bad++;
            $display("FAIL stall_leftover: got %0d pending want 0", addr_q.size() + rgb_exp_q.size());
        end
        tick();
    endtask

    task automatic test_busy();
        int lat;
        int dones;
        int rel;
        ram_word = 24'h3C3C3C;
        addr_mix = 1'b1;
        rises = 0;
        dones = 0;
        lat = -1;
        start_line(5'd12, 4'd2, 1'b1);
        for (int i = 0; i < 260; i++) begin
            tick();
            rel = cyc - begin_cyc;
            bus.next_line_begin = (rel == 50 || rel == 120);
            bus.next_line_addr = 5'd17;
            bus.next_line_pwm = 4'd3;
            bus.base_addr = 1'b0;
            if (bus.next_line_done === 1'b1) begin
                dones++;
                lat = rel;
            end
        end
        bus.next_line_begin = 1'b0;
        total++;
        if (dones !== 1) begin bad++; $display("FAIL busy_done_count: got %0d want 1", dones); end
        total++;
        if (lat !== 193) begin bad++; $display("FAIL busy_latency: got %0d want 193", lat); end
        total++;
        if (rises !== 64) begin bad++; $display("FAIL busy_sclk_rises: got %0d want 64", rises); end
        total++;
        if (addr_q.size() + rgb_exp_q.size() !== 0) begin
            bad++;
            $display("FAIL busy_leftover: got %0d pending want 0", addr_q.size() + rgb_exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int lat1;
        int lat2;
        ram_word = 24'h0F0F0F;
        addr_mix = 1'b1;
        rises = 0;
        start_line(5'd30, 4'd0, 1'b1);
        wait_done(lat1);
        tick();
        total++;
        if (bus.next_line_done !== 1'b0) begin bad++; $display("FAIL b2b_done_width: got %b want 0", bus.next_line_done); end
        start_line(5'd31, 4'd1, 1'b0);
        wait_done(lat2);
        total++;
        if (lat1 !== 193) begin bad++; $display("FAIL b2b_latency1: got %0d want 193", lat1); end
        total++;
        if (lat2 !== 193) begin bad++; $display("FAIL b2b_latency2: got %0d want 193", lat2); end
        total++;
        if (rises !== 128) begin bad++; $display("FAIL b2b_sclk_rises: got %0d want 128", rises); end
        total++;
        if (addr_q.size() + rgb_exp_q.size() !== 0) begin
            bad++;
            $display("FAIL b2b_leftover: got %0d pending want 0", addr_q.size() + rgb_exp_q.size());
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int lat;
        int ndone;
        ram_word = 24'hABCDEF;
        addr_mix = 1'b0;
        rises = 0;
        start_line(5'd7, 4'd2, 1'b1);
        repeat (9) tick();
        rst_n = 1'b0;
        #1;
        total++;
        if ({rgb, sclk, bus.ram_re, bus.next_line_done} !== 9'b0) begin
            bad++;
            $display("FAIL midreset_outputs: got rgb=%b sclk=%b re=%b done=%b want all 0", rgb, sclk, bus.ram_re, bus.next_line_done);
        end
        total++;
        if (bus.ram_addr !== 12'h0) begin bad++; $display("FAIL midreset_addr: got %h want 000", bus.ram_addr); end
        addr_q.delete();
        rgb_exp_q.delete();
        repeat (3) tick();
        rst_n = 1'b1;
        rises = 0;
        ndone = 0;
        repeat (250) begin
            tick();
            if (bus.next_line_done !== 1'b0) ndone++;
        end
        total++;
        if (ndone !== 0 || rises !== 0) begin
            bad++;
            $display("FAIL midreset_quiet: got done=%0d sclk rises=%0d want 0/0", ndone, rises);
        end
        start_line(5'd3, 4'd1, 1'b0);
        wait_done(lat);
        total++;
        if (lat !== 193) begin bad++; $display("FAIL midreset_restart_latency: got %0d want 193", lat); end
        total++;
        if (rises !== 64) begin bad++; $display("FAIL midreset_restart_rises: got %0d want 64", rises); end
        total++;
        if (addr_q.size() + rgb_exp_q.size() !== 0) begin
            bad++;
            $display("FAIL midreset_leftover: got %0d pending want 0", addr_q.size() + rgb_exp_q.size());
        end
        tick();
    endtask

    initial begin
        #(40 * 50000);
        $display("FAIL watchdog: got no finish after 50000 cycles, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.next_line_begin = 1'b0;
        bus.next_line_addr = '0;
        bus.next_line_pwm = '0;
        bus.base_addr = 1'b0;
        bus.ram_en = 1'b1;
`ifdef LINE_TEST_PATTERN_EN
        bus.test_pattern = 1'b0;
`endif
        test_reset();
        test_basic();
        test_plane();
        test_stall();
        test_busy();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
